// File: rtl/bin2bcd_arbiter_pkg.sv
// Shared types and constants for the bin2bcd converter arbiter and its
// round-robin picker.
package bin2bcd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int DIGIT_W         = 4;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin2bcd_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so ptr_i sits at bit 0,
// take the lowest set bit, then map the offset back to a requester index.
module bin2bcd_arbiter_rr_picker
    import bin2bcd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    localparam logic [PTR_W:0] NREQ_EXT = (PTR_W + 1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [PTR_W-1:0]     off_s;
    logic [PTR_W:0]       sum_s;

    // Rotate, priority-encode from the top down so the lowest offset wins, un-rotate.
    always_comb begin
        dbl_s = {req_i, req_i} >> ptr_i;
        rot_s = dbl_s[NUM_REQ-1:0];
        off_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? PTR_W'(i) : off_s;
        end
        sum_s   = {1'b0, ptr_i} + {1'b0, off_s};
        idx_o   = (sum_s >= NREQ_EXT) ? PTR_W'(sum_s - NREQ_EXT) : PTR_W'(sum_s);
        valid_o = |req_i;
    end

endmodule

// File: rtl/bin2bcd_arbiter.sv
// Shares one bin2bcd converter among NUM_REQ requesters: pick round-robin,
// strobe start, wait for finished (or time out), return the result with done.
module bin2bcd_arbiter
    import bin2bcd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int BIN_W   = 16,
    parameter int BCD_W   = 5 * DIGIT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*BIN_W-1:0] req_bin,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [BCD_W-1:0]         bcd_out,
    output logic                     timeout_err,
    output logic                     busy,
    output logic                     conv_start,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic                     conv_finished,
    input  logic [BCD_W-1:0]         conv_bcd
);

    localparam int PTR_W = ptr_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     idx_q, idx_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 tmo_q, tmo_d;
    logic [BIN_W-1:0]     conv_bin_q, conv_bin_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q;
    logic                 conv_start_q;

    logic [PTR_W-1:0]     pick_idx_s;
    logic                 pick_valid_s;
    logic [PTR_W-1:0]     next_ptr_s;
    logic [BIN_W-1:0]     sel_bin_s;

    bin2bcd_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Operand mux for the picked requester.
    always_comb begin
        sel_bin_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_bin_s = (pick_idx_s == PTR_W'(i)) ? req_bin[i*BIN_W +: BIN_W] : sel_bin_s;
        end
    end

    // Priority restarts just past the requester that was served last.
    always_comb begin
        next_ptr_s = (idx_q == LAST_IDX) ? '0 : idx_q + PTR_W'(1);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        done_d     = '0;
        bcd_d      = bcd_q;
        tmo_d      = 1'b0;
        conv_bin_d = conv_bin_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    idx_d      = pick_idx_s;
                    grant_d    = ONE_HOT0 << pick_idx_s;
                    conv_bin_d = sel_bin_s;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_finished) begin
                    bcd_d    = conv_bcd;
                    done_d   = grant_q;
                    rr_ptr_d = next_ptr_s;
                    state_d  = ST_RELEASE;
                end else if (cnt_q == TMO_LAST) begin
                    // Converter never answered: report an empty result and free the slot.
                    bcd_d    = '0;
                    done_d   = grant_q;
                    tmo_d    = 1'b1;
                    rr_ptr_d = next_ptr_s;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Hold the grant until the converter is back in its start state.
                if (!conv_finished) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            bcd_q        <= '0;
            tmo_q        <= 1'b0;
            conv_bin_q   <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            bcd_q        <= bcd_d;
            tmo_q        <= tmo_d;
            conv_bin_q   <= conv_bin_d;
            cnt_q        <= cnt_d;
            busy_q       <= (state_d != ST_IDLE);
            conv_start_q <= (state_d == ST_ISSUE);
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign bcd_out     = bcd_q;
    assign timeout_err = tmo_q;
    assign busy        = busy_q;
    assign conv_start  = conv_start_q;
    assign conv_bin    = conv_bin_q;

endmodule

// File: tb/tb_bin2bcd_arbiter.sv
// Directed bench for bin2bcd_arbiter with a behavioural converter and a
// scoreboard of expected (requester, BCD, timeout) results.
module tb_bin2bcd_arbiter;

    localparam int LAT  = 40;
    localparam int HOLD = 31;

    typedef struct {
        int          idx;
        logic [19:0] bcd;
        logic        tmo;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [63:0] req_bin = 64'd0;
    logic [3:0]  grant, done;
    logic [19:0] bcd_out;
    logic        timeout_err, busy, conv_start;
    logic [15:0] conv_bin;
    logic        conv_finished = 1'b0;
    logic [19:0] conv_bcd = 20'd0;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   n_starts = 0;
    int   cv_cnt = 0;
    int   cv_hold = 0;
    bit   cv_act = 1'b0;
    bit   conv_never = 1'b0;

    bin2bcd_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_bin       (req_bin),
        .grant         (grant),
        .done          (done),
        .bcd_out       (bcd_out),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .conv_start    (conv_start),
        .conv_bin      (conv_bin),
        .conv_finished (conv_finished),
        .conv_bcd      (conv_bcd)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] to_bcd(input logic [15:0] b);
        logic [19:0] r;
        int v;
        v = int'(b);
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Behavioural converter: finished rises LAT cycles after start, held HOLD cycles.
    always @(posedge clock) begin
        if (reset) begin
            cv_act        <= 1'b0;
            cv_cnt        <= 0;
            cv_hold       <= 0;
            conv_finished <= 1'b0;
        end else if (conv_start && !conv_never) begin
            cv_act   <= 1'b1;
            cv_cnt   <= 0;
            conv_bcd <= to_bcd(conv_bin);
        end else if (cv_act) begin
            cv_cnt <= cv_cnt + 1;
            if (cv_cnt == LAT - 1) begin
                conv_finished <= 1'b1;
                cv_act        <= 1'b0;
                cv_hold       <= HOLD;
            end
        end else if (conv_finished) begin
            if (cv_hold == 1) conv_finished <= 1'b0;
            cv_hold <= cv_hold - 1;
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (conv_start === 1'b1) begin
            n_starts   <= n_starts + 1;
            last_start <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int idx, input logic [19:0] bcd, input logic tmo);
        exp_t e;
        e.idx = idx;
        e.bcd = bcd;
        e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        exp_t e;
        bit   seen;
        logic [3:0] oh;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clock);
            if (done !== 4'b0000) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            check("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.idx;
                check("done_onehot", {28'd0, done}, {28'd0, oh});
                check("bcd_out", {12'd0, bcd_out}, {12'd0, e.bcd});
                check("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
                check("grant_at_done", {28'd0, grant}, e.tmo ? 32'd0 : {28'd0, oh});
                check("busy_at_done", {31'd0, busy}, e.tmo ? 32'd0 : 32'd1);
                check("done_latency", cyc - last_start, e.tmo ? 32'd256 : 32'd42);
            end
            req = req & ~done;
            @(negedge clock);
            check("done_single", {28'd0, done}, 32'd0);
            check("tmo_single", {31'd0, timeout_err}, 32'd0);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    int   s0;
    int   nidle;
    bit   any_done;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_done", {28'd0, done}, 32'd0);
        check("rst_bcd", {12'd0, bcd_out}, 32'd0);
        check("rst_flags", {29'd0, timeout_err, busy, conv_start}, 32'd0);
        check("rst_conv_bin", {16'd0, conv_bin}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Round-robin over all four requesters.
        req_bin = {16'd4444, 16'd333, 16'd22, 16'd1};
        s0 = n_starts;
        push(0, 20'h00001, 1'b0);
        push(1, 20'h00022, 1'b0);
        push(2, 20'h00333, 1'b0);
        push(3, 20'h04444, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) wait_done(150);
        wait_idle(nidle);
        check("rr_starts", n_starts - s0, 32'd4);

        // Fairness: requesters 0 and 2 keep asking.
        req_bin[15:0]  = 16'd9999;
        req_bin[47:32] = 16'd65535;
        push(0, 20'h09999, 1'b0);
        push(2, 20'h65535, 1'b0);
        push(0, 20'h09999, 1'b0);
        push(2, 20'h65535, 1'b0);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(150);
            if (k < 2) req = req | (k == 0 ? 4'b0001 : 4'b0100);
        end
        wait_idle(nidle);

        // Single request, then busy must fall once finished drops.
        req_bin[15:0] = 16'd1234;
        s0 = n_starts;
        push(0, 20'h01234, 1'b0);
        req = 4'b0001;
        wait_done(150);
        wait_idle(nidle);
        check("release_len", nidle, HOLD - 1);
        check("finished_low_at_idle", {31'd0, conv_finished}, 32'd0);
        check("single_starts", n_starts - s0, 32'd1);

        // Zero operand.
        req_bin[31:16] = 16'd0;
        push(1, 20'h00000, 1'b0);
        req = 4'b0010;
        wait_done(150);
        wait_idle(nidle);

        // Converter never finishes.
        conv_never = 1'b1;
        req_bin[47:32] = 16'd77;
        push(2, 20'h00000, 1'b1);
        req = 4'b0100;
        wait_done(400);
        conv_never = 1'b0;
        push(0, 20'h01234, 1'b0);
        req = 4'b0001;
        wait_done(150);
        wait_idle(nidle);

        // Reset in the middle of WAIT.
        req = 4'b0010;
        for (int k = 0; k < 20 && conv_start !== 1'b1; k++) @(negedge clock);
        check("mid_start_seen", {31'd0, conv_start}, 32'd1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        req = 4'b0000;
        @(negedge clock);
        check("mrst_grant", {28'd0, grant}, 32'd0);
        check("mrst_done", {28'd0, done}, 32'd0);
        check("mrst_bcd", {12'd0, bcd_out}, 32'd0);
        check("mrst_flags", {29'd0, timeout_err, busy, conv_start}, 32'd0);
        check("mrst_conv_bin", {16'd0, conv_bin}, 32'd0);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done !== 4'b0000) any_done = 1'b1;
        end
        check("mrst_no_done", {31'd0, any_done}, 32'd0);

        // Priority restarts at requester 0 after reset.
        req_bin[15:0] = 16'd9999;
        push(0, 20'h09999, 1'b0);
        push(3, 20'h04444, 1'b0);
        req = 4'b1001;
        wait_done(150);
        wait_done(150);
        wait_idle(nidle);
        check("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_arbiter.md
Name: bin2bcd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one binary-to-BCD converter (the bin2bcd datapath and its control unit) among several calculator requesters: operand A display, operand B display, ALU result and status display. The block latches the winning requester's binary word, issues a one-cycle start, waits for the converter's finished flag, and captures the BCD result. It then returns the result with a done pulse and waits for the converter to drop finished and re-enter its start state before serving the next request. The block sits between the calculator top-level/display mux and the bin2bcd instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BIN_W, 16, binary input width per requester
BCD_W, 20, BCD result width (4 bits per digit; 5 digits for 16-bit)
TIMEOUT, 255, maximum WAIT cycles before abort (counter width is clog2(TIMEOUT+1))

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  level request per requester; held until done seen
req_bin  input  NUM_REQ*BIN_W  packed binary words; slice i belongs to req[i]
grant  output  NUM_REQ  one-hot; identifies the requester currently in service
done  output  NUM_REQ  one-cycle pulse to the served requester
bcd_out  output  BCD_W  result register; valid while done pulses and holds until next capture
timeout_err  output  1  one-cycle pulse coincident with done on abort
busy  output  1  high in every state except IDLE
conv_start  output  1  start strobe to the converter
conv_bin  output  BIN_W  latched operand to the converter
conv_finished  input  1  converter finished flag
conv_bcd  input  BCD_W  converter BCD result

Behaviour:
- Reset: state=IDLE; grant=0, done=0, bcd_out=0, timeout_err=0, busy=0, conv_start=0, conv_bin=0, rr_ptr=0, timeout counter=0. Reset mid-operation aborts with no done pulse; the converter is reset from the same reset.
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: if any req bit is high, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Latch the index, set grant one-hot, latch conv_bin=req_bin slice, go to ISSUE. The decision is registered: 1 cycle after req is sampled.
- ISSUE: conv_start=1 for exactly this one cycle; go to WAIT. conv_bin stays stable from ISSUE through RELEASE.
- WAIT: count cycles.
  - On conv_finished=1: bcd_out<=conv_bcd; done[idx] pulses on the next cycle; rr_ptr<=idx+1 (wrap); go to RELEASE.
  - If the count reaches TIMEOUT with finished still 0: bcd_out<=0, done[idx] and timeout_err pulse, rr_ptr advances, go to IDLE.
- RELEASE: hold grant until conv_finished=0 (converter back in its start state), then clear grant and go to IDLE. If finished is already low on entry, 1 cycle.
- Requester contract: req must deassert no later than the cycle after done. A req that is still high when the block re-enters IDLE is served again.
- Requests sampled only in IDLE. A req rising during service waits. A req that drops before grant is ignored. A req that drops during service still completes; done pulses and the result is discarded by the requester.
- Simultaneous requests: round-robin from rr_ptr. After reset, requester 0 has highest priority.
- done is a pure registered pulse, never high for 2 consecutive cycles. At most one done/grant bit is set at any time.

Decomposition:
- Shared package/header: state encodings (2-bit: IDLE=0, ISSUE=1, WAIT=2, RELEASE=3), default TIMEOUT, digit width constant 4.
- Sub-module rr_picker (combinational): rotate by rr_ptr, priority-encode, un-rotate. Outputs winner index plus a valid flag. Reusable by future shared-resource arbiters such as the ALU or display.

Test Plan:
- Single request: req=4'b0001, req_bin[15:0]=16'd1234, behavioural converter (finished after 40 cycles, held 31 cycles) -> grant=0001, one conv_start pulse, done=0001 once, bcd_out=20'h01234, busy low after finished drops.
- Round-robin: req=4'b1111 held with values 1/22/333/4444, each deasserted after its done -> service order 0,1,2,3; bcd_out 0x00001, 0x00022, 0x00333, 0x04444; exactly 4 conv_start pulses.
- Fairness after a win: req0 and req2 both repeat continuously -> alternating grants 0,2,0,2; never two consecutive grants to 0.
- Boundary values: 16'd0 -> 20'h00000; 16'd65535 -> 20'h65535; 16'd9999 -> 20'h09999.
- Timeout: converter never asserts finished, req=0100 -> after 255 WAIT cycles, done=0100 and timeout_err pulse together, bcd_out=0, state IDLE, next request served normally.
- Reset mid-WAIT: assert reset 10 cycles into WAIT -> all outputs 0 the next cycle, no done pulse, rr_ptr=0, fresh req3 served correctly.
